// File: rtl/pwm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared definitions for the PWM ramp controller slice:
//   - VAL_W        : width of the signed duty/setpoint values (16)
//   - DEFAULT_STEP : default maximum duty change per PWM period
//   - state_e      : FSM state encoding (IDLE=0, RAMP=1, HOLD=2, FAULT=3)
//   - val_t        : signed duty value type
// -----------------------------------------------------------------------------
package pwm_ctrl_pkg;

   localparam int VAL_W = 16;

   localparam logic [VAL_W-1:0] DEFAULT_STEP = 16'd64;

   typedef logic signed [VAL_W-1:0] val_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RAMP  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

endpackage : pwm_ctrl_pkg

// File: rtl/pwm_slew_step.sv
// -----------------------------------------------------------------------------
// pwm_slew_step
// Purely combinational slew limiter: computes the next duty value that moves
// cur_val_i toward tgt_i by at most STEP, landing exactly on the target when
// it is within reach. Never overshoots and never wraps at the signed limits.
//
// Ports:
//   cur_val_i  in  16  current duty value (signed)
//   tgt_i      in  16  target duty value (signed)
//   nxt_val_o  out 16  slew-limited next duty value (signed)
//   reached_o  out 1   target is within one step (nxt_val_o == tgt_i)
// -----------------------------------------------------------------------------
module pwm_slew_step
   import pwm_ctrl_pkg::*;
#(
   parameter logic [VAL_W-1:0] STEP = DEFAULT_STEP
) (
   input  logic signed [VAL_W-1:0] cur_val_i,
   input  logic signed [VAL_W-1:0] tgt_i,
   output logic signed [VAL_W-1:0] nxt_val_o,
   output logic                    reached_o
);

   // One extra bit so the full span (-32768 .. +32767) never overflows.
   logic signed [VAL_W:0] diff;
   logic        [VAL_W:0] diff_mag;
   logic        [VAL_W:0] step_ext;

   assign diff     = {tgt_i[VAL_W-1], tgt_i} - {cur_val_i[VAL_W-1], cur_val_i};
   assign diff_mag = diff[VAL_W] ? $unsigned(-diff) : $unsigned(diff);
   assign step_ext = {1'b0, STEP};
   assign reached_o = (diff_mag <= step_ext);

   // When more than one step away, cur +/- STEP lies strictly between cur and
   // tgt, so plain 16-bit arithmetic is exact here (no wrap possible).
   always_comb begin
      nxt_val_o = tgt_i;
      if (!reached_o) begin
         if (diff[VAL_W]) begin
            nxt_val_o = cur_val_i - $signed(STEP);
         end else begin
            nxt_val_o = cur_val_i + $signed(STEP);
         end
      end
   end

endmodule : pwm_slew_step

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
// Slew-rate-limited duty command generator for a PWM core. Accepts a signed
// setpoint over a valid/ready handshake and ramps val_out toward it by at most
// STEP per PWM period (pwm_ready strobe). A level fault forces the output to
// zero until acknowledged; en=0 ramps the output down to zero.
//
// Optional feature (macro PWM_RAMP_WDOG_EN): setpoint watchdog. If no new
// setpoint is accepted for WDOG_TICKS PWM periods while driving a nonzero
// target, the target is cleared to 0 and the sticky wdog_trip flag is set.
// Without the macro there is no watchdog counter and wdog_trip is tied low.
//
// Ports:
//   clk        in  1   clock, all logic on rising edge
//   rst_n      in  1   asynchronous active-low reset
//   en         in  1   run enable (low: ramp to zero then idle)
//   sp         in  16  signed setpoint
//   sp_valid   in  1   setpoint offer
//   sp_ready   out 1   setpoint accept (low only in FAULT)
//   pwm_ready  in  1   PWM period-boundary strobe
//   fault      in  1   level fault request
//   fault_clr  in  1   fault acknowledge pulse
//   val_out    out 16  registered signed duty command
//   at_sp      out 1   val_out equals effective target (not in FAULT)
//   state      out 2   FSM state code
//   wdog_trip  out 1   sticky watchdog flag
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter logic [VAL_W-1:0] STEP       = DEFAULT_STEP,
   parameter int               WDOG_TICKS = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic signed [VAL_W-1:0] sp,
   input  logic                    sp_valid,
   output logic                    sp_ready,
   input  logic                    pwm_ready,
   input  logic                    fault,
   input  logic                    fault_clr,
   output logic signed [VAL_W-1:0] val_out,
   output logic                    at_sp,
   output logic [1:0]              state,
   output logic                    wdog_trip
);

   generate
      if (STEP == '0 || WDOG_TICKS < 1) begin : g_bad_param
         $error("pwm_ramp_ctrl: STEP must be nonzero and WDOG_TICKS >= 1");
      end
   endgenerate

   state_e state_q, state_d;
   val_t   val_q, val_d;
   val_t   tgt_q, tgt_d;

   val_t   eff_tgt;
   val_t   slew_nxt;
   logic   slew_reached;
   logic   sp_acc;
   logic   wdog_fire;

   assign sp_ready = (state_q != ST_FAULT);
   assign sp_acc   = sp_valid && sp_ready;
   assign eff_tgt  = en ? tgt_q : '0;

   assign val_out = val_q;
   assign state   = state_q;
   assign at_sp   = (val_q == eff_tgt) && (state_q != ST_FAULT);

   pwm_slew_step #(
      .STEP (STEP)
   ) u_slew (
      .cur_val_i (val_q),
      .tgt_i     (eff_tgt),
      .nxt_val_o (slew_nxt),
      .reached_o (slew_reached)
   );

   // Next-state / datapath. The step always uses tgt_q as it was before this
   // edge, so a setpoint accepted together with pwm_ready takes effect on the
   // following period boundary.
   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      tgt_d   = tgt_q;

      if (sp_acc) begin
         tgt_d = sp;
      end else if (wdog_fire) begin
         tgt_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (eff_tgt != val_q) begin
               state_d = ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (val_q == eff_tgt) begin
               state_d = ST_HOLD;
            end else if (pwm_ready) begin
               val_d = slew_nxt;
               if (slew_reached) begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (!en && (val_q == '0)) begin
               state_d = ST_IDLE;
            end else if (eff_tgt != val_q) begin
               state_d = ST_RAMP;
            end
         end
         ST_FAULT: begin
            val_d = '0;
            // An acknowledge while the fault is still asserted is ignored.
            if (fault_clr && !fault) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            val_d   = '0;
         end
      endcase

      // Fault overrides every other event in the same cycle.
      if (fault) begin
         state_d = ST_FAULT;
         val_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         val_q   <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         tgt_q   <= tgt_d;
      end
   end

`ifdef PWM_RAMP_WDOG_EN
   localparam int WD_W = (WDOG_TICKS > 1) ? $clog2(WDOG_TICKS) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_TICKS - 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            wd_trip_q, wd_trip_d;

   // Counts period boundaries since the last accepted setpoint while actively
   // driving a nonzero target; stops counting once the target is cleared.
   always_comb begin
      wd_cnt_d  = wd_cnt_q;
      wd_trip_d = wd_trip_q;
      wdog_fire = 1'b0;
      if (sp_acc) begin
         wd_cnt_d  = '0;
         wd_trip_d = 1'b0;
      end else if (pwm_ready && (tgt_q != '0) &&
                   ((state_q == ST_RAMP) || (state_q == ST_HOLD))) begin
         if (wd_cnt_q == WD_LAST) begin
            wdog_fire = 1'b1;
            wd_trip_d = 1'b1;
            wd_cnt_d  = '0;
         end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q  <= '0;
         wd_trip_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         wd_trip_q <= wd_trip_d;
      end
   end

   assign wdog_trip = wd_trip_q;
`else
   assign wdog_fire = 1'b0;
   assign wdog_trip = 1'b0;
`endif

endmodule : pwm_ramp_ctrl
